// File: rtl/aixh_mxc_inner_bwd_collector.sv
// aixh_mxc_inner_bwd_collector
// Sink end of the MxConv inner-array backward path. Each per-row backward
// lane is captured, queued in a small per-lane FIFO, and the FIFOs are
// round-robin arbitrated onto a single valid/ready output port.
//
// Output handshake: o_out_vld/o_out_dat/o_out_lane form a strict valid/ready
// source. Once o_out_vld rises, data and lane stay stable until the cycle in
// which i_out_rdy is sampled high; a beat transfers on each rising edge where
// both o_out_vld and i_out_rdy are 1. o_out_vld never depends on i_out_rdy
// combinationally.
//
// The backward lanes have no back-pressure, so a beat arriving at a full FIFO
// is dropped and flagged in the sticky o_ovf bit for that lane.
//
// Optional feature: define AIXH_MXC_BWDCOL_DROP_CNT_EN to build the saturating
// dropped-beat counter on o_drop_cnt; otherwise o_drop_cnt is tied to 0.
module aixh_mxc_inner_bwd_collector #(
    parameter int YCELLS     = 4,
    parameter int BWD_DWIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                       aixh_core_clk2x,
    input  logic                                       aixh_core_rst,
    input  logic [YCELLS-1:0]                          i_bwd_vld,
    input  logic [YCELLS*BWD_DWIDTH-1:0]               i_bwd_dat,
    output logic                                       o_out_vld,
    input  logic                                       i_out_rdy,
    output logic [BWD_DWIDTH-1:0]                      o_out_dat,
    output logic [((YCELLS > 1) ? $clog2(YCELLS) : 1)-1:0] o_out_lane,
    output logic [YCELLS-1:0]                          o_ovf,
    input  logic                                       i_ovf_clr,
    output logic                                       o_idle,
    output logic [7:0]                                 o_drop_cnt
);

    localparam int LW = (YCELLS > 1) ? $clog2(YCELLS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    // Capture stage
    logic [YCELLS-1:0]     r_cap_vld;
    logic [BWD_DWIDTH-1:0] r_cap_dat [YCELLS];

    // Lane FIFOs (pointers carry one extra wrap bit)
    logic [BWD_DWIDTH-1:0] r_mem [YCELLS][FIFO_DEPTH];
    logic [AW:0]           r_wr  [YCELLS];
    logic [AW:0]           r_rd  [YCELLS];

    // Output register and round-robin pointer
    logic                  r_out_vld;
    logic [BWD_DWIDTH-1:0] r_out_dat;
    logic [LW-1:0]         r_out_lane;
    logic [LW-1:0]         r_rr;
    logic [YCELLS-1:0]     r_ovf;

    logic [YCELLS-1:0]     w_nempty;
    logic [YCELLS-1:0]     w_full;
    logic [YCELLS-1:0]     w_pop;
    logic [YCELLS-1:0]     w_push;
    logic [YCELLS-1:0]     w_drop;
    logic                  w_gnt_vld;
    logic [LW-1:0]         w_gnt_lane;
    logic                  w_load;
    logic [AW-1:0]         w_head_idx;
    logic [BWD_DWIDTH-1:0] w_head_dat;

    // Capture every lane's valid each cycle; data only loads on its valid
    always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst) begin
        if (aixh_core_rst) begin
            r_cap_vld <= '0;
            for (int i = 0; i < YCELLS; i++) begin
                r_cap_dat[i] <= '0;
            end
        end else begin
            r_cap_vld <= i_bwd_vld;
            for (int i = 0; i < YCELLS; i++) begin
                if (i_bwd_vld[i]) begin
                    r_cap_dat[i] <= i_bwd_dat[i*BWD_DWIDTH +: BWD_DWIDTH];
                end
            end
        end
    end

    // Per-lane FIFO status from the wrap-bit pointers
    always_comb begin
        w_nempty = '0;
        w_full   = '0;
        for (int i = 0; i < YCELLS; i++) begin
            w_nempty[i] = (r_wr[i] != r_rd[i]);
            w_full[i]   = (r_wr[i][AW] != r_rd[i][AW]) &&
                          (r_wr[i][AW-1:0] == r_rd[i][AW-1:0]);
        end
    end

    // Round-robin search: first non-empty lane at or after r_rr
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_gnt_vld  = 1'b0;
        w_gnt_lane = '0;
        for (int k = 0; k < YCELLS; k++) begin
            v_idx = int'(r_rr) + k;
            if (v_idx >= YCELLS) begin
                v_idx = v_idx - YCELLS;
            end
            if (!w_gnt_vld && w_nempty[v_idx]) begin
                w_gnt_vld  = 1'b1;
                w_gnt_lane = LW'(v_idx);
            end
        end
    end

    // Output slot is free when empty or being taken this cycle
    assign w_load     = (!r_out_vld || i_out_rdy) && w_gnt_vld;
    assign w_head_idx = r_rd[w_gnt_lane][AW-1:0];
    assign w_head_dat = r_mem[w_gnt_lane][w_head_idx];

    // Pop the granted lane; a full lane still accepts if popped this cycle
    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int i = 0; i < YCELLS; i++) begin
            w_pop[i]  = w_load && (w_gnt_lane == LW'(i));
            w_push[i] = r_cap_vld[i] && (!w_full[i] || w_pop[i]);
            w_drop[i] = r_cap_vld[i] && w_full[i] && !w_pop[i];
        end
    end

    // FIFO storage is not reset; pointers define what is valid
    always_ff @(posedge aixh_core_clk2x) begin
        for (int i = 0; i < YCELLS; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr[i][AW-1:0]] <= r_cap_dat[i];
            end
        end
    end

    // FIFO read/write pointers
    always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst) begin
        if (aixh_core_rst) begin
            for (int i = 0; i < YCELLS; i++) begin
                r_wr[i] <= '0;
                r_rd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < YCELLS; i++) begin
                if (w_push[i]) begin
                    r_wr[i] <= r_wr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd[i] <= r_rd[i] + 1'b1;
                end
            end
        end
    end

    // Output register and round-robin pointer advance on each grant
    always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst) begin
        if (aixh_core_rst) begin
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_lane <= '0;
            r_rr       <= '0;
        end else begin
            if (w_load) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= w_head_dat;
                r_out_lane <= w_gnt_lane;
                r_rr       <= (w_gnt_lane == LW'(YCELLS - 1)) ? LW'(0) : (w_gnt_lane + 1'b1);
            end else if (r_out_vld && i_out_rdy) begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    // Sticky overflow flags; a new drop wins over a clear
    always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst) begin
        if (aixh_core_rst) begin
            r_ovf <= '0;
        end else if (i_ovf_clr) begin
            r_ovf <= w_drop;
        end else begin
            r_ovf <= r_ovf | w_drop;
        end
    end

`ifdef AIXH_MXC_BWDCOL_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic [8:0] w_ndrop;
    logic [8:0] w_sum;

    // Number of lanes dropping a beat this cycle
    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < YCELLS; i++) begin
            w_ndrop = w_ndrop + 9'(w_drop[i]);
        end
    end

    assign w_sum = {1'b0, r_drop_cnt} + w_ndrop;

    // Saturating drop counter; a clear reloads with this cycle's drops
    always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst) begin
        if (aixh_core_rst) begin
            r_drop_cnt <= '0;
        end else if (i_ovf_clr) begin
            r_drop_cnt <= w_ndrop[7:0];
        end else begin
            r_drop_cnt <= (w_sum > 9'd255) ? 8'hFF : w_sum[7:0];
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    assign o_drop_cnt = 8'h00;
`endif

    assign o_out_vld  = r_out_vld;
    assign o_out_dat  = r_out_dat;
    assign o_out_lane = r_out_lane;
    assign o_ovf      = r_ovf;
    assign o_idle     = (w_nempty == '0) && (r_cap_vld == '0) && !r_out_vld;

endmodule
